// File: rtl/pcie_axi_pkg.sv
// rtl/pcie_axi_pkg.sv - shared FSM encoding, response codes and parity helper
package pcie_axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_DATA = 2'd1,
      ST_WR_RESP = 2'd2,
      ST_RD_DATA = 2'd3
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // odd parity over one byte: 1 when the byte holds an even number of ones
   function automatic logic byte_par(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/pcie_axi_bram.sv
// rtl/pcie_axi_bram.sv - single-port byte-writable memory with registered read
module pcie_axi_bram #(
   parameter int DATA_W = 256,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [DATA_W/8-1:0]   we,
   input  logic [IDX_W-1:0]      addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // byte-lane writes plus a read that holds its output while en is low
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < DATA_W/8; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/pcie_axi_target_mem.sv
// rtl/pcie_axi_target_mem.sv - AXI4 INCR-burst target in front of a block memory
module pcie_axi_target_mem
   import pcie_axi_pkg::*;
#(
   parameter int DATA_W = 256,
   parameter int DEPTH  = 1024,
   parameter int ID_W   = 8,
   parameter int ADDR_W = 64
) (
   input  logic                  axiclk,
   input  logic                  axi_rst,
   input  logic [ADDR_W-1:0]     s_awaddr,
   input  logic [ID_W-1:0]       s_awid,
   input  logic [7:0]            s_awlen,
   input  logic [2:0]            s_awsize,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [DATA_W/8-1:0]   s_wstrb,
   input  logic                  s_wlast,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [ID_W-1:0]       s_bid,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [ADDR_W-1:0]     s_araddr,
   input  logic [ID_W-1:0]       s_arid,
   input  logic [7:0]            s_arlen,
   input  logic [2:0]            s_arsize,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [DATA_W-1:0]     s_rdata,
   output logic [DATA_W/8-1:0]   s_rdata_par,
   output logic [ID_W-1:0]       s_rid,
   output logic [1:0]            s_rresp,
   output logic                  s_rlast,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic [15:0]           wr_cnt,
   output logic [15:0]           rd_cnt,
   output logic                  busy
);

   localparam int NB   = DATA_W / 8;
   localparam int OFF  = $clog2(NB);
   localparam int IDXW = $clog2(DEPTH);

   state_t              state, nxt;
   logic                ready_q;
   logic [ID_W-1:0]     id_q;
   logic [7:0]          len_q;
   logic [2:0]          size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [8:0]          cnt_q;
   logic                err_q;
   logic [1:0]          bresp_q;
   logic                v1_q, l1_q;
   logic                rvalid_q, rlast_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   mem_rdata;

   logic aw_fire, ar_fire, wr_beat, wr_last, wlast_bad;
   logic stall, rd_issue, rd_issue_last, rd_done, b_done;
   logic [ADDR_W-1:0] addr_inc;

   assign addr_inc      = ADDR_W'(1) << size_q;
   assign wr_beat       = (state == ST_WR_DATA) && s_wvalid;
   assign wr_last       = wr_beat && (cnt_q == {1'b0, len_q});
   assign wlast_bad     = s_wlast != (cnt_q == {1'b0, len_q});
   assign stall         = rvalid_q && !s_rready;
   assign rd_issue      = (state == ST_RD_DATA) && !stall && (cnt_q <= {1'b0, len_q});
   assign rd_issue_last = cnt_q == {1'b0, len_q};
   assign rd_done       = rvalid_q && s_rready && rlast_q;
   assign b_done        = (state == ST_WR_RESP) && s_bready;

   // state register
   always_ff @(posedge axiclk or posedge axi_rst) begin
      if (axi_rst) state <= ST_IDLE;
      else         state <= nxt;
   end

   // next state and handshake outputs; a same-cycle AW wins over AR
   always_comb begin
      nxt       = state;
      s_awready = 1'b0;
      s_arready = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
      busy      = (state != ST_IDLE);
      aw_fire   = 1'b0;
      ar_fire   = 1'b0;
      case (state)
         ST_IDLE: begin
            s_awready = ready_q;
            s_arready = ready_q && !s_awvalid;
            aw_fire   = ready_q && s_awvalid;
            ar_fire   = ready_q && !s_awvalid && s_arvalid;
            if (aw_fire)      nxt = ST_WR_DATA;
            else if (ar_fire) nxt = ST_RD_DATA;
         end
         ST_WR_DATA: begin
            s_wready = 1'b1;
            if (wr_last) nxt = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            s_bvalid = 1'b1;
            if (s_bready) nxt = ST_IDLE;
         end
         ST_RD_DATA: begin
            if (rd_done) nxt = ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   // burst bookkeeping, read pipeline and completion counters
   always_ff @(posedge axiclk or posedge axi_rst) begin
      if (axi_rst) begin
         ready_q  <= 1'b0;
         id_q     <= '0;
         len_q    <= '0;
         size_q   <= '0;
         addr_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         bresp_q  <= RESP_OKAY;
         v1_q     <= 1'b0;
         l1_q     <= 1'b0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rdata_q  <= '0;
         wr_cnt   <= '0;
         rd_cnt   <= '0;
      end else begin
         // holds AW/AR off for one edge after reset release
         ready_q <= 1'b1;
         if (aw_fire) begin
            id_q   <= s_awid;
            len_q  <= s_awlen;
            size_q <= s_awsize;
            addr_q <= s_awaddr;
            cnt_q  <= '0;
            err_q  <= 1'b0;
         end else if (ar_fire) begin
            id_q   <= s_arid;
            len_q  <= s_arlen;
            size_q <= s_arsize;
            addr_q <= s_araddr;
            cnt_q  <= '0;
         end else if (wr_beat || rd_issue) begin
            addr_q <= addr_q + addr_inc;
            cnt_q  <= cnt_q + 9'd1;
         end
         if (wr_beat && wlast_bad) err_q <= 1'b1;
         if (wr_last) bresp_q <= (err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
         // two-stage read pipe: memory output stage, then output register
         if (!stall) begin
            rdata_q  <= mem_rdata;
            rvalid_q <= v1_q;
            rlast_q  <= l1_q;
            v1_q     <= rd_issue;
            l1_q     <= rd_issue && rd_issue_last;
         end
         if (b_done && wr_cnt != 16'hFFFF)  wr_cnt <= wr_cnt + 16'd1;
         if (rd_done && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end
   end

   pcie_axi_bram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDXW)
   ) u_bram (
      .clk   (axiclk),
      .en    (wr_beat || rd_issue),
      .we    (wr_beat ? s_wstrb : '0),
      .addr  (addr_q[OFF +: IDXW]),
      .wdata (s_wdata),
      .rdata (mem_rdata)
   );

   assign s_bid    = id_q;
   assign s_bresp  = bresp_q;
   assign s_rid    = id_q;
   assign s_rresp  = RESP_OKAY;
   assign s_rdata  = rdata_q;
   assign s_rvalid = rvalid_q;
   assign s_rlast  = rlast_q;

   for (genvar i = 0; i < NB; i++) begin : g_par
      assign s_rdata_par[i] = byte_par(rdata_q[8*i +: 8]);
   end

endmodule

// File: tb/tb_pcie_axi_target_mem.sv
// tb/tb_pcie_axi_target_mem.sv - randomized self-checking bench for pcie_axi_target_mem
module tb_pcie_axi_target_mem;
   localparam int DATA_W = 256;
   localparam int DEPTH  = 16;
   localparam int ID_W   = 8;
   localparam int ADDR_W = 64;
   localparam int NB     = DATA_W / 8;

   logic axiclk = 1'b0;
   logic axi_rst;
   logic [ADDR_W-1:0] s_awaddr, s_araddr;
   logic [ID_W-1:0] s_awid, s_arid, s_bid, s_rid;
   logic [7:0] s_awlen, s_arlen;
   logic [2:0] s_awsize, s_arsize;
   logic s_awvalid, s_awready, s_arvalid, s_arready;
   logic [DATA_W-1:0] s_wdata, s_rdata;
   logic [NB-1:0] s_wstrb, s_rdata_par;
   logic s_wlast, s_wvalid, s_wready;
   logic [1:0] s_bresp, s_rresp;
   logic s_bvalid, s_bready, s_rlast, s_rvalid, s_rready;
   logic [15:0] wr_cnt, rd_cnt;
   logic busy;

   pcie_axi_target_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
      .axiclk(axiclk), .axi_rst(axi_rst),
      .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
      .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
      .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rdata_par(s_rdata_par), .s_rid(s_rid), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .busy(busy)
   );

   always #5 axiclk = ~axiclk;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] model_mem [DEPTH];
   int model_wr = 0;
   int model_rd = 0;

   logic [DATA_W-1:0] wbeat [256];
   logic [NB-1:0]     wstrb_a [256];
   logic [DATA_W-1:0] rbeat [256];
   logic              rlast_a [256];
   logic [NB-1:0]     rpar_a [256];
   logic [ID_W-1:0]   rid_a [256];
   logic [1:0]        rresp_a [256];
   int rlat;
   bit rstable;

   function automatic int word_of(input logic [63:0] base, input int k, input int size);
      logic [63:0] a;
      a = base + 64'(k) * (64'd1 << size);
      return int'((a / 64'(NB)) % 64'(DEPTH));
   endfunction

   function automatic void model_write(input logic [63:0] base, input int len, input int size);
      for (int k = 0; k <= len; k++) begin
         int idx;
         idx = word_of(base, k, size);
         for (int b = 0; b < NB; b++)
            if (wstrb_a[k][b]) model_mem[idx][8*b +: 8] = wbeat[k][8*b +: 8];
      end
   endfunction

   function automatic logic [NB-1:0] exp_par(input logic [DATA_W-1:0] d);
      logic [NB-1:0] p;
      for (int b = 0; b < NB; b++) p[b] = ($countones(d[8*b +: 8]) % 2) == 0;
      return p;
   endfunction

   function automatic logic [DATA_W-1:0] rand_word();
      logic [DATA_W-1:0] w;
      for (int i = 0; i < DATA_W/32; i++) w[32*i +: 32] = $urandom;
      return w;
   endfunction

   task automatic aw_phase(input logic [63:0] addr, input logic [7:0] id, input int len,
                           input int size, output bit to);
      bit got;
      int n;
      s_awaddr = addr; s_awid = id; s_awlen = 8'(len); s_awsize = 3'(size); s_awvalid = 1'b1;
      got = 0; n = 0;
      while (!got && n < 200) begin
         @(negedge axiclk); got = s_awready;
         @(posedge axiclk); #1; n++;
      end
      s_awvalid = 1'b0;
      to = !got;
   endtask

   task automatic w_b_phase(input int len, input int wlast_at, output logic [7:0] bid,
                            output logic [1:0] bresp, output bit to);
      bit got;
      int n;
      to = 0;
      for (int k = 0; k <= len && !to; k++) begin
         s_wdata = wbeat[k]; s_wstrb = wstrb_a[k]; s_wlast = (k == wlast_at); s_wvalid = 1'b1;
         got = 0; n = 0;
         while (!got && n < 200) begin
            @(negedge axiclk); got = s_wready;
            @(posedge axiclk); #1; n++;
         end
         to = !got;
      end
      s_wvalid = 1'b0; s_wlast = 1'b0;
      s_bready = 1'b1; got = 0; n = 0; bid = '0; bresp = '0;
      while (!to && !got && n < 200) begin
         @(negedge axiclk); got = s_bvalid; bid = s_bid; bresp = s_bresp;
         @(posedge axiclk); #1; n++;
      end
      s_bready = 1'b0;
      to = to || !got;
   endtask

   task automatic axi_write(input logic [63:0] addr, input logic [7:0] id, input int len,
                            input int size, input int wlast_at, output logic [7:0] bid,
                            output logic [1:0] bresp, output bit to);
      aw_phase(addr, id, len, size, to);
      bid = '0; bresp = '0;
      if (!to) w_b_phase(len, wlast_at, bid, bresp, to);
      if (!to) begin
         model_write(addr, len, size);
         model_wr++;
      end
   endtask

   function automatic logic rr(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (cyc % 2) == 0;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic axi_read(input logic [63:0] addr, input logic [7:0] id, input int len,
                           input int size, input int mode, output bit to);
      bit got, prev_stall;
      int n, cyc, rcount;
      logic [DATA_W-1:0] pd;
      logic [NB-1:0] pp;
      logic pl;
      logic [ID_W-1:0] pid;
      s_araddr = addr; s_arid = id; s_arlen = 8'(len); s_arsize = 3'(size); s_arvalid = 1'b1;
      got = 0; n = 0;
      while (!got && n < 200) begin
         @(negedge axiclk); got = s_arready;
         @(posedge axiclk); #1; n++;
      end
      s_arvalid = 1'b0;
      rlat = -1; rstable = 1; rcount = 0; cyc = 0; prev_stall = 0;
      pd = '0; pp = '0; pl = 0; pid = '0;
      s_rready = rr(mode, 0);
      while (got && rcount <= len && cyc < 3000) begin
         @(negedge axiclk);
         if (s_rvalid) begin
            if (rlat < 0) rlat = cyc;
            if (prev_stall && (s_rdata !== pd || s_rlast !== pl || s_rid !== pid ||
                               s_rdata_par !== pp)) rstable = 0;
         end
         if (s_rvalid && s_rready) begin
            rbeat[rcount] = s_rdata; rlast_a[rcount] = s_rlast; rpar_a[rcount] = s_rdata_par;
            rid_a[rcount] = s_rid; rresp_a[rcount] = s_rresp;
            rcount++;
         end
         prev_stall = s_rvalid && !s_rready;
         pd = s_rdata; pp = s_rdata_par; pl = s_rlast; pid = s_rid;
         @(posedge axiclk); #1; cyc++;
         s_rready = rr(mode, cyc);
      end
      s_rready = 1'b0;
      to = !got || rcount <= len;
      if (!to) model_rd++;
   endtask

   task automatic test_reset();
      axi_rst = 1'b1;
      s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awvalid = 1'b0;
      s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
      s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arvalid = 1'b0;
      s_rready = 1'b0;
      repeat (3) @(posedge axiclk);
      #1;
      checks++;
      if ({s_bvalid, s_rvalid, s_rlast, s_wready, s_awready, s_arready, busy, wr_cnt, rd_cnt,
           s_bid, s_rid, s_bresp, s_rresp} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got bvalid=%b rvalid=%b rlast=%b wready=%b awready=%b arready=%b busy=%b wr=%0d rd=%0d bid=%h rid=%h bresp=%b rresp=%b, want all 0",
                  s_bvalid, s_rvalid, s_rlast, s_wready, s_awready, s_arready, busy, wr_cnt,
                  rd_cnt, s_bid, s_rid, s_bresp, s_rresp);
      end
      axi_rst = 1'b0;
      @(negedge axiclk);
      checks++;
      if ({s_awready, s_arready} !== 2'b00) begin
         errors++;
         $display("FAIL reset_release_early: awready/arready=%b, want 00", {s_awready, s_arready});
      end
      @(posedge axiclk); #1;
      checks++;
      if ({s_awready, s_arready} !== 2'b11) begin
         errors++;
         $display("FAIL reset_release_ready: awready/arready=%b, want 11", {s_awready, s_arready});
      end
      model_wr = 0; model_rd = 0;
   endtask

   task automatic test_single();
      logic [7:0] bid; logic [1:0] bresp; bit to;
      logic [DATA_W-1:0] pat;
      pat = {NB{8'hA5}};
      wbeat[0] = pat; wstrb_a[0] = '1;
      axi_write(64'h40, 8'h12, 0, 5, 0, bid, bresp, to);
      checks++;
      if (to || bid !== 8'h12 || bresp !== 2'b00) begin
         errors++;
         $display("FAIL single_bresp: to=%0d bid=%h bresp=%b, want bid=12 bresp=00", to, bid, bresp);
      end
      axi_read(64'h40, 8'h12, 0, 5, 0, to);
      checks++;
      if (to || rbeat[0] !== pat || rid_a[0] !== 8'h12 || rlast_a[0] !== 1'b1 ||
          rresp_a[0] !== 2'b00) begin
         errors++;
         $display("FAIL single_read: to=%0d data=%h rid=%h rlast=%b rresp=%b, want data=%h rid=12 rlast=1 rresp=00",
                  to, rbeat[0], rid_a[0], rlast_a[0], rresp_a[0], pat);
      end
      checks++;
      if (rpar_a[0] !== {NB{1'b1}}) begin
         errors++;
         $display("FAIL single_par: par=%h, want all ones", rpar_a[0]);
      end
      checks++;
      if (rlat !== 2) begin
         errors++;
         $display("FAIL single_latency: first rvalid after %0d cycles, want 2", rlat);
      end
      checks++;
      if (wr_cnt !== 16'(model_wr) || rd_cnt !== 16'(model_rd)) begin
         errors++;
         $display("FAIL single_counts: wr_cnt=%0d rd_cnt=%0d, want %0d %0d", wr_cnt, rd_cnt,
                  model_wr, model_rd);
      end
   endtask

   task automatic test_burst_backpressure();
      logic [7:0] bid; logic [1:0] bresp; bit to;
      for (int k = 0; k < 8; k++) begin
         wbeat[k] = DATA_W'(k); wstrb_a[k] = '1;
      end
      axi_write(64'h0, 8'h21, 7, 5, 7, bid, bresp, to);
      checks++;
      if (to || bresp !== 2'b00 || bid !== 8'h21) begin
         errors++;
         $display("FAIL burst_bresp: to=%0d bid=%h bresp=%b, want 21 00", to, bid, bresp);
      end
      axi_read(64'h0, 8'h33, 7, 5, 1, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL burst_read_timeout: beats missing, want 8");
      end
      for (int k = 0; k < 8 && !to; k++) begin
         checks++;
         if (rbeat[k] !== DATA_W'(k) || rlast_a[k] !== (k == 7) || rid_a[k] !== 8'h33) begin
            errors++;
            $display("FAIL burst_beat%0d: data=%h rlast=%b rid=%h, want data=%0d rlast=%0d rid=33",
                     k, rbeat[k], rlast_a[k], rid_a[k], k, (k == 7));
         end
      end
      checks++;
      if (!rstable || rlat !== 2) begin
         errors++;
         $display("FAIL burst_stall: stable=%0d latency=%0d, want 1 and 2", rstable, rlat);
      end
      checks++;
      if (rd_cnt !== 16'(model_rd) || s_rvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL burst_done: rd_cnt=%0d rvalid=%b busy=%b, want %0d 0 0", rd_cnt, s_rvalid,
                  busy, model_rd);
      end
   endtask

   task automatic test_partial_strobe();
      logic [7:0] bid; logic [1:0] bresp; bit to;
      logic [DATA_W-1:0] want;
      want = {{(NB-4){8'hFF}}, 32'h0};
      wbeat[0] = '1; wstrb_a[0] = '1;
      axi_write(64'd96, 8'h01, 0, 5, 0, bid, bresp, to);
      wbeat[0] = '0; wstrb_a[0] = 32'h0000000F;
      axi_write(64'd96, 8'h02, 0, 5, 0, bid, bresp, to);
      axi_read(64'd96, 8'h03, 0, 5, 2, to);
      checks++;
      if (to || rbeat[0] !== want || rbeat[0] !== model_mem[3]) begin
         errors++;
         $display("FAIL partial_strobe: to=%0d data=%h, want %h", to, rbeat[0], want);
      end
   endtask

   task automatic test_wrap_wlast();
      logic [7:0] bid; logic [1:0] bresp; bit to;
      logic [DATA_W-1:0] saved [4];
      int words [4];
      words = '{14, 15, 0, 1};
      for (int k = 0; k < 4; k++) begin
         wbeat[k] = rand_word(); wstrb_a[k] = '1; saved[k] = wbeat[k];
      end
      axi_write(64'(14 * NB), 8'h44, 3, 5, 3, bid, bresp, to);
      checks++;
      if (to || bresp !== 2'b00) begin
         errors++;
         $display("FAIL wrap_bresp: to=%0d bresp=%b, want 00", to, bresp);
      end
      for (int k = 0; k < 4; k++) begin
         axi_read(64'(words[k] * NB), 8'h45, 0, 5, 0, to);
         checks++;
         if (to || rbeat[0] !== saved[k]) begin
            errors++;
            $display("FAIL wrap_word%0d: data=%h, want %h", words[k], rbeat[0], saved[k]);
         end
      end
      axi_read(64'(14 * NB), 8'h46, 3, 5, 2, to);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (to || rbeat[k] !== saved[k] || rlast_a[k] !== (k == 3)) begin
            errors++;
            $display("FAIL wrap_read_beat%0d: data=%h rlast=%b, want %h %0d", k, rbeat[k],
                     rlast_a[k], saved[k], (k == 3));
         end
      end
      for (int k = 0; k < 4; k++) begin
         wbeat[k] = rand_word(); wstrb_a[k] = '1;
      end
      axi_write(64'(5 * NB), 8'h47, 3, 5, 1, bid, bresp, to);
      checks++;
      if (to || bresp !== 2'b10 || bid !== 8'h47) begin
         errors++;
         $display("FAIL early_wlast: to=%0d bid=%h bresp=%b, want 47 10", to, bid, bresp);
      end
      axi_write(64'(9 * NB), 8'h48, 2, 5, -1, bid, bresp, to);
      checks++;
      if (to || bresp !== 2'b10) begin
         errors++;
         $display("FAIL missing_wlast: to=%0d bresp=%b, want 10", to, bresp);
      end
      axi_read(64'(5 * NB), 8'h49, 3, 5, 0, to);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (to || rbeat[k] !== model_mem[5 + k]) begin
            errors++;
            $display("FAIL early_wlast_data%0d: data=%h, want %h", k, rbeat[k], model_mem[5 + k]);
         end
      end
   endtask

   task automatic test_collision();
      logic [7:0] bid; logic [1:0] bresp; bit to;
      logic [DATA_W-1:0] pat;
      pat = rand_word();
      wbeat[0] = pat; wstrb_a[0] = '1;
      s_awaddr = 64'(7 * NB); s_awid = 8'h61; s_awlen = 8'd0; s_awsize = 3'd5; s_awvalid = 1'b1;
      s_araddr = 64'(7 * NB); s_arid = 8'h62; s_arlen = 8'd0; s_arsize = 3'd5; s_arvalid = 1'b1;
      @(negedge axiclk);
      checks++;
      if ({s_awready, s_arready} !== 2'b10) begin
         errors++;
         $display("FAIL collision_ready: awready/arready=%b, want 10", {s_awready, s_arready});
      end
      @(posedge axiclk); #1;
      s_awvalid = 1'b0;
      w_b_phase(0, 0, bid, bresp, to);
      if (!to) begin
         model_write(64'(7 * NB), 0, 5);
         model_wr++;
      end
      axi_read(64'(7 * NB), 8'h62, 0, 5, 0, to);
      checks++;
      if (to || bid !== 8'h61 || rbeat[0] !== pat || rid_a[0] !== 8'h62) begin
         errors++;
         $display("FAIL collision_order: to=%0d bid=%h rid=%h data=%h, want 61 62 %h", to, bid,
                  rid_a[0], rbeat[0], pat);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit got, to;
      int n;
      s_araddr = '0; s_arid = 8'h70; s_arlen = 8'd15; s_arsize = 3'd5; s_arvalid = 1'b1;
      got = 0; n = 0;
      while (!got && n < 200) begin
         @(negedge axiclk); got = s_arready;
         @(posedge axiclk); #1; n++;
      end
      s_arvalid = 1'b0;
      s_rready = 1'b1;
      repeat (5) @(posedge axiclk);
      #1;
      checks++;
      if (!got || s_rvalid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midburst_active: accepted=%0d rvalid=%b busy=%b, want 1 1 1", got,
                  s_rvalid, busy);
      end
      axi_rst = 1'b1;
      #1;
      checks++;
      if (s_rvalid !== 1'b0 || busy !== 1'b0 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
         errors++;
         $display("FAIL midburst_reset: rvalid=%b busy=%b rd=%0d wr=%0d, want 0 0 0 0", s_rvalid,
                  busy, rd_cnt, wr_cnt);
      end
      @(posedge axiclk); #1;
      s_rready = 1'b0;
      checks++;
      if (s_rvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midburst_next: rvalid=%b busy=%b, want 0 0", s_rvalid, busy);
      end
      axi_rst = 1'b0;
      model_wr = 0; model_rd = 0;
      axi_read(64'd0, 8'h71, 15, 5, 2, to);
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (to || rbeat[k] !== model_mem[k] || rlast_a[k] !== (k == 15)) begin
            errors++;
            $display("FAIL after_reset_beat%0d: data=%h rlast=%b, want %h %0d", k, rbeat[k],
                     rlast_a[k], model_mem[k], (k == 15));
         end
      end
      checks++;
      if (rd_cnt !== 16'(model_rd) || rlat !== 2 || !rstable) begin
         errors++;
         $display("FAIL after_reset_done: rd_cnt=%0d lat=%0d stable=%0d, want %0d 2 1", rd_cnt,
                  rlat, rstable, model_rd);
      end
   endtask

   task automatic test_random();
      logic [7:0] bid; logic [1:0] bresp; bit to;
      for (int k = 0; k < DEPTH; k++) begin
         wbeat[k] = rand_word(); wstrb_a[k] = '1;
      end
      axi_write(64'd0, 8'h80, DEPTH - 1, 5, DEPTH - 1, bid, bresp, to);
      for (int it = 0; it < 12; it++) begin
         int len, size, rlen, rsize;
         logic [63:0] addr, raddr;
         logic [7:0] id;
         len = $urandom_range(0, 20); size = $urandom_range(4, 6);
         addr = (64'($urandom) << 20) | 64'($urandom_range(0, 1023) * 16);
         id = 8'($urandom);
         for (int k = 0; k <= len; k++) begin
            wbeat[k] = rand_word(); wstrb_a[k] = NB'($urandom);
         end
         axi_write(addr, id, len, size, len, bid, bresp, to);
         checks++;
         if (to || bid !== id || bresp !== 2'b00) begin
            errors++;
            $display("FAIL rand%0d_bresp: to=%0d bid=%h bresp=%b, want %h 00", it, to, bid, bresp, id);
         end
         rlen = $urandom_range(0, 20); rsize = $urandom_range(4, 6);
         raddr = (64'($urandom) << 24) | 64'($urandom_range(0, 1023) * 16);
         axi_read(raddr, id, rlen, rsize, 2, to);
         for (int k = 0; k <= rlen; k++) begin
            logic [DATA_W-1:0] want;
            want = model_mem[word_of(raddr, k, rsize)];
            checks++;
            if (to || rbeat[k] !== want || rlast_a[k] !== (k == rlen) || rid_a[k] !== id ||
                rpar_a[k] !== exp_par(want) || rresp_a[k] !== 2'b00) begin
               errors++;
               $display("FAIL rand%0d_beat%0d: data=%h rlast=%b rid=%h par=%h, want %h %0d %h %h",
                        it, k, rbeat[k], rlast_a[k], rid_a[k], rpar_a[k], want, (k == rlen), id,
                        exp_par(want));
            end
         end
         checks++;
         if (!rstable || rlat !== 2) begin
            errors++;
            $display("FAIL rand%0d_stall: stable=%0d lat=%0d, want 1 2", it, rstable, rlat);
         end
      end
      checks++;
      if (wr_cnt !== 16'(model_wr) || rd_cnt !== 16'(model_rd)) begin
         errors++;
         $display("FAIL rand_counts: wr=%0d rd=%0d, want %0d %0d", wr_cnt, rd_cnt, model_wr,
                  model_rd);
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_burst_backpressure();
      test_partial_strobe();
      test_wrap_wlast();
      test_collision();
      test_reset_mid_burst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
